// File: rtl/maquina_lectura_pkg.sv
// -----------------------------------------------------------------------------
// maquina_lectura_pkg
// Definitions shared between the RTC read sequencer and the edit/write machine:
//   - RTC register addresses (control plus the eight time/date registers)
//   - index-to-address mapping used while sweeping the register file
//   - read-FSM state encoding
// -----------------------------------------------------------------------------
package maquina_lectura_pkg;

  localparam logic [7:0] DIR_CTRL = 8'h00;
  localparam logic [7:0] DIR_SEG  = 8'h21;
  localparam logic [7:0] DIR_MIN  = 8'h22;
  localparam logic [7:0] DIR_HORA = 8'h23;
  localparam logic [7:0] DIR_DATE = 8'h24;
  localparam logic [7:0] DIR_MES  = 8'h25;
  localparam logic [7:0] DIR_ANO  = 8'h26;
  localparam logic [7:0] DIR_DSEM = 8'h27;
  localparam logic [7:0] DIR_NSEM = 8'h28;

  // Number of registers in one sweep and the index of the last one
  localparam int unsigned N_REGS   = 9;
  localparam logic [3:0]  K_ULTIMO = 4'd8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    TURN = 3'd2,
    READ = 3'd3,
    REC  = 3'd4
  } estado_lec_e;

  // RTC address for sweep index k (control first, then 0x21..0x28)
  function automatic logic [7:0] dir_de_indice(input logic [3:0] k);
    logic [7:0] dir;
    case (k)
      4'd0:    dir = DIR_CTRL;
      4'd1:    dir = DIR_SEG;
      4'd2:    dir = DIR_MIN;
      4'd3:    dir = DIR_HORA;
      4'd4:    dir = DIR_DATE;
      4'd5:    dir = DIR_MES;
      4'd6:    dir = DIR_ANO;
      4'd7:    dir = DIR_DSEM;
      4'd8:    dir = DIR_NSEM;
      default: dir = DIR_CTRL;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/maquina_lectura_contador_fase.sv
// -----------------------------------------------------------------------------
// contador_fase
// Loadable down-counter timing the ADDR and READ phases. Loading value N-1
// makes fin_o high on the N-th cycle after the load, i.e. on the last cycle
// of an N-cycle phase. The count saturates at zero.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   carga_i : load valor_i on the next edge
//   valor_i : load value (phase length minus one)
//   fin_o   : count is zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module contador_fase #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         carga_i,
  input  logic [W-1:0] valor_i,
  output logic         fin_o
);

  logic [W-1:0] cuenta_q;
  logic [W-1:0] cuenta_d;

  // Next count: load, decrement, or hold at zero
  always_comb begin
    cuenta_d = cuenta_q;
    if (carga_i) begin
      cuenta_d = valor_i;
    end else if (cuenta_q != {W{1'b0}}) begin
      cuenta_d = cuenta_q - W'(1);
    end else begin
      cuenta_d = cuenta_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cuenta_q <= {W{1'b0}};
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign fin_o = (cuenta_q == {W{1'b0}});

endmodule

// File: rtl/maquina_lectura.sv
// -----------------------------------------------------------------------------
// maquina_lectura
// RTC read sequencer. On request it sweeps control (0x00) and 0x21..0x28 over
// the multiplexed bus (ADDR -> TURN -> READ -> REC per register) and latches
// each byte into its own output register. Yields to the writer: 'escribe'
// blocks a new sweep and aborts a running one at the next REC, so a strobe
// is never cut short.
// Ports:
//   clk, reset (async, active-low)
//   inicio      : sweep request, sampled in IDLE
//   escribe     : writer owns the bus
//   dato_in     : RTC read data
//   cs_n, ad_n, wr_n, rd_n, dir_out, dir_oe : registered bus controls
//   control .. num_semana : latched register images
//   ocupado     : not in IDLE
//   listo       : one-cycle pulse after a complete sweep
// -----------------------------------------------------------------------------
module maquina_lectura
  import maquina_lectura_pkg::*;
#(
  parameter int T_ADDR = 4,
  parameter int T_RD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       escribe,
  input  logic [7:0] dato_in,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] dir_out,
  output logic       dir_oe,
  output logic [7:0] control,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] date,
  output logic [7:0] mes,
  output logic [7:0] ano,
  output logic [7:0] dia_sem,
  output logic [7:0] num_semana,
  output logic       ocupado,
  output logic       listo
);

  localparam int T_MAX = (T_ADDR > T_RD) ? T_ADDR : T_RD;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CW-1:0] CARGA_ADDR = CW'(T_ADDR - 1);
  localparam logic [CW-1:0] CARGA_RD   = CW'(T_RD - 1);

  estado_lec_e   estado_q, estado_d;
  logic [3:0]    k_q, k_d;
  logic          carga_s;
  logic [CW-1:0] valor_s;
  logic          fin_s;
  logic          latch_s;

  logic       cs_n_q, cs_n_d, ad_n_q, ad_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic       dir_oe_q, dir_oe_d, ocupado_q, ocupado_d, listo_q, listo_d;
  logic [7:0] dir_out_q, dir_out_d;
  logic [7:0] regs_q [N_REGS];

  contador_fase #(.W(CW)) u_contador_fase (
    .clk_i   (clk),
    .rst_ni  (reset),
    .carga_i (carga_s),
    .valor_i (valor_s),
    .fin_o   (fin_s)
  );

  // Next state, sweep index, phase-counter loads, then output decode of the
  // next state so every bus control comes straight out of a flop
  always_comb begin
    estado_d = estado_q;
    k_d      = k_q;
    carga_s  = 1'b0;
    valor_s  = CARGA_ADDR;
    latch_s  = 1'b0;
    listo_d  = 1'b0;
    case (estado_q)
      IDLE: begin
        if (inicio && !escribe) begin
          estado_d = ADDR;
          k_d      = 4'd0;
          carga_s  = 1'b1;
          valor_s  = CARGA_ADDR;
        end else begin
          estado_d = IDLE;
        end
      end
      ADDR: begin
        if (fin_s) begin
          estado_d = TURN;
        end else begin
          estado_d = ADDR;
        end
      end
      TURN: begin
        estado_d = READ;
        carga_s  = 1'b1;
        valor_s  = CARGA_RD;
      end
      READ: begin
        if (fin_s) begin
          estado_d = REC;
          latch_s  = 1'b1;
        end else begin
          estado_d = READ;
        end
      end
      REC: begin
        // Completion wins over an abort on the last register
        if (k_q == K_ULTIMO) begin
          estado_d = IDLE;
          k_d      = 4'd0;
          listo_d  = 1'b1;
        end else if (escribe) begin
          estado_d = IDLE;
          k_d      = 4'd0;
        end else begin
          estado_d = ADDR;
          k_d      = k_q + 4'd1;
          carga_s  = 1'b1;
          valor_s  = CARGA_ADDR;
        end
      end
      default: begin
        estado_d = IDLE;
        k_d      = 4'd0;
      end
    endcase

    cs_n_d    = 1'b1;
    ad_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    dir_oe_d  = 1'b0;
    dir_out_d = 8'h00;
    ocupado_d = (estado_d != IDLE);
    case (estado_d)
      ADDR: begin
        cs_n_d    = 1'b0;
        ad_n_d    = 1'b0;
        wr_n_d    = 1'b0;
        dir_oe_d  = 1'b1;
        dir_out_d = dir_de_indice(k_d);
      end
      TURN: begin
        cs_n_d = 1'b0;
      end
      READ: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      IDLE, REC: begin
        cs_n_d = 1'b1;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // State, index and registered bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= IDLE;
      k_q       <= 4'd0;
      cs_n_q    <= 1'b1;
      ad_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      dir_oe_q  <= 1'b0;
      dir_out_q <= 8'h00;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      k_q       <= k_d;
      cs_n_q    <= cs_n_d;
      ad_n_q    <= ad_n_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      dir_oe_q  <= dir_oe_d;
      dir_out_q <= dir_out_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
    end
  end

  // Register images: only entry k is written, on the edge ending READ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (latch_s) begin
      regs_q[k_q] <= dato_in;
    end
  end

  assign cs_n       = cs_n_q;
  assign ad_n       = ad_n_q;
  assign wr_n       = wr_n_q;
  assign rd_n       = rd_n_q;
  assign dir_oe     = dir_oe_q;
  assign dir_out    = dir_out_q;
  assign ocupado    = ocupado_q;
  assign listo      = listo_q;
  assign control    = regs_q[0];
  assign segundos   = regs_q[1];
  assign minutos    = regs_q[2];
  assign horas      = regs_q[3];
  assign date       = regs_q[4];
  assign mes        = regs_q[5];
  assign ano        = regs_q[6];
  assign dia_sem    = regs_q[7];
  assign num_semana = regs_q[8];

endmodule

// File: tb/tb_maquina_lectura.sv
// -----------------------------------------------------------------------------
// tb_maquina_lectura
// Bench for the RTC read sequencer: default-timing instance plus a
// T_ADDR = T_RD = 1 instance, each served by an RTC bus model holding
// random register contents.
// -----------------------------------------------------------------------------
module tb_maquina_lectura;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, inicio, escribe, inicio2, escribe2;
  logic [7:0] dato_in, dato_in2;
  logic       cs_n, ad_n, wr_n, rd_n, dir_oe, ocupado, listo;
  logic [7:0] dir_out, control, segundos, minutos, horas, date, mes, ano, dia_sem, num_semana;
  logic       cs_n2, ad_n2, wr_n2, rd_n2, dir_oe2, ocupado2, listo2;
  logic [7:0] dir_out2, control2, segundos2, minutos2, horas2, date2, mes2, ano2, dia_sem2, num_semana2;

  maquina_lectura #(.T_ADDR(4), .T_RD(4)) dut (
    .clk(clk), .reset(rst_n), .inicio(inicio), .escribe(escribe), .dato_in(dato_in),
    .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n), .dir_out(dir_out), .dir_oe(dir_oe),
    .control(control), .segundos(segundos), .minutos(minutos), .horas(horas), .date(date),
    .mes(mes), .ano(ano), .dia_sem(dia_sem), .num_semana(num_semana),
    .ocupado(ocupado), .listo(listo)
  );

  maquina_lectura #(.T_ADDR(1), .T_RD(1)) dut2 (
    .clk(clk), .reset(rst_n), .inicio(inicio2), .escribe(escribe2), .dato_in(dato_in2),
    .cs_n(cs_n2), .ad_n(ad_n2), .wr_n(wr_n2), .rd_n(rd_n2), .dir_out(dir_out2), .dir_oe(dir_oe2),
    .control(control2), .segundos(segundos2), .minutos(minutos2), .horas(horas2), .date(date2),
    .mes(mes2), .ano(ano2), .dia_sem(dia_sem2), .num_semana(num_semana2),
    .ocupado(ocupado2), .listo(listo2)
  );

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] mem      [9];
  logic [7:0] exp_regs [9];
  logic [7:0] addr_lat  = 8'h00;
  logic [7:0] addr_lat2 = 8'h00;

  // Expected address for sweep index k
  function automatic logic [7:0] dir_ref(input int k);
    return (k == 0) ? 8'h00 : 8'(32 + k);
  endfunction

  // RTC contents seen at a bus address; unknown addresses return filler
  function automatic logic [7:0] resp(input logic [7:0] a);
    int idx;
    idx = int'(a) - 32;
    if (a == 8'h00) return mem[0];
    else if (idx >= 1 && idx <= 8) return mem[idx];
    else return 8'hEE;
  endfunction

  // RTC bus model: latches the address during wr_n low, drives data while rd_n low
  always @(posedge clk) begin
    if (!wr_n)  addr_lat  <= dir_out;
    if (!wr_n2) addr_lat2 <= dir_out2;
  end
  always @(negedge clk) begin
    dato_in  = rd_n  ? 8'hEE : resp(addr_lat);
    dato_in2 = rd_n2 ? 8'hEE : resp(addr_lat2);
  end

  // {cs_n, ad_n, wr_n, rd_n, dir_oe, ocupado, listo, dir_out}
  function automatic logic [14:0] vec();
    return {cs_n, ad_n, wr_n, rd_n, dir_oe, ocupado, listo, dir_out};
  endfunction

  function automatic logic [7:0] rd_reg(input int i);
    case (i)
      0: return control;   1: return segundos; 2: return minutos;
      3: return horas;     4: return date;     5: return mes;
      6: return ano;       7: return dia_sem;  8: return num_semana;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rd_reg2(input int i);
    case (i)
      0: return control2;  1: return segundos2; 2: return minutos2;
      3: return horas2;    4: return date2;     5: return mes2;
      6: return ano2;      7: return dia_sem2;  8: return num_semana2;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_chk++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic comprobar_regs(input string tag);
    for (int i = 0; i < 9; i++) chequear($sformatf("%s reg%0d", tag, i), rd_reg(i), exp_regs[i]);
  endtask

  // One sweep on the default instance, checked cycle by cycle against the
  // phase sequence 4xADDR, TURN, 4xREAD, REC per register.
  // k_abort >= 0 raises escribe during the second READ cycle of that index.
  // hold keeps inicio high throughout (ignored while busy, re-triggers after listo).
  task automatic barrido(input int k_abort, input bit hold);
    for (int i = 0; i < 9; i++) mem[i] = mem[i] ^ 8'($urandom_range(1, 255));
    inicio = 1'b1;
    tick();
    if (!hold) inicio = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 4; i++) begin
        chequear($sformatf("addr k%0d c%0d", k, i), vec(), 15'h0E00 | {7'h00, dir_ref(k)});
        tick();
      end
      chequear($sformatf("turn k%0d", k), vec() & 15'h7F00, 15'h3A00);
      tick();
      for (int i = 0; i < 4; i++) begin
        if (k == k_abort && i == 1) escribe = 1'b1;
        chequear($sformatf("read k%0d c%0d", k, i), vec() & 15'h7F00, 15'h3200);
        tick();
      end
      exp_regs[k] = mem[k];
      chequear($sformatf("rec k%0d", k), vec() & 15'h5B00, 15'h5A00);
      chequear($sformatf("latch k%0d", k), rd_reg(k), exp_regs[k]);
      tick();
      if (k == k_abort) begin
        chequear("abort idle", vec() & 15'h7F00, 15'h7800);
        return;
      end
    end
    chequear("listo pulse", vec() & 15'h7F00, 15'h7900);
    tick();
    if (hold) chequear("retrigger", vec(), 15'h0E00);
    else      chequear("listo drop", vec() & 15'h7F00, 15'h7800);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [35:0] wr_obs, cs_obs, wr_exp, cs_exp;
    int c;
    rst_n = 1'b0; inicio = 1'b0; escribe = 1'b0; inicio2 = 1'b0; escribe2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mem[i] = 8'($urandom);
      exp_regs[i] = 8'h00;
    end
    repeat (2) tick();
    chequear("reset vec", vec(), 15'h7800);
    comprobar_regs("reset");
    rst_n = 1'b1;
    tick();
    chequear("idle", vec(), 15'h7800);

    barrido(-1, 1'b0);
    comprobar_regs("sweepA");

    barrido(3, 1'b0);
    comprobar_regs("abort");

    // escribe still high: requests are blocked
    inicio = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chequear($sformatf("blocked c%0d", i), {cs_n, ocupado}, 2'b10);
    end
    escribe = 1'b0;
    tick();
    chequear("unblock start", vec(), 15'h0E00);
    inicio = 1'b0;

    // advance to the middle of ADDR for k = 5, then reset between edges
    repeat (50) tick();
    chequear("addr k5", vec(), 15'h0E25);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
    chequear("async reset vec", vec(), 15'h7800);
    comprobar_regs("async reset");
    tick();
    rst_n = 1'b1;
    tick();

    barrido(-1, 1'b1);
    comprobar_regs("sweepC");
    rst_n = 1'b0;
    inicio = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Timing corner: 4-cycle register period, 36-cycle sweep
    for (int i = 0; i < 9; i++) mem[i] = 8'($urandom);
    wr_obs = '1; cs_obs = '1;
    for (int i = 0; i < 36; i++) begin
      wr_exp[i] = (i % 4 != 0);
      cs_exp[i] = (i % 4 == 3);
    end
    inicio2 = 1'b1;
    tick();
    inicio2 = 1'b0;
    c = 0;
    while (listo2 !== 1'b1 && c < 100) begin
      if (c < 36) begin
        wr_obs[c] = wr_n2;
        cs_obs[c] = cs_n2;
      end
      tick();
      c++;
    end
    chequear("corner listo cycle", 64'(c), 64'd36);
    chequear("corner wr_n pattern", wr_obs, wr_exp);
    chequear("corner cs_n pattern", cs_obs, cs_exp);
    chequear("corner listo/ocupado", {listo2, ocupado2}, 2'b10);
    for (int i = 0; i < 9; i++) chequear($sformatf("corner reg%0d", i), rd_reg2(i), mem[i]);
    tick();
    chequear("corner listo drop", {listo2, ocupado2, cs_n2}, 3'b001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
